// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial ADD / SUB / EQ sequencer built around one
// full-adder slice and a carry flop, processing operands LSB first.
// Optional feature macro: SERIAL_ADDER_CTRL_OVF_EN adds the signed-overflow
// output ovf (carry into MSB xor carry out of MSB, captured for ADD/SUB).
module serial_adder_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             eq
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_EQ  = 2'b10;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] acc;
  logic [1:0]       op_q;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             is_eq;
  logic             sum_bit;
  logic             maj_bit;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  // Bit-slice: one full adder on the LSBs of the shift registers.
  always_comb begin
    is_eq    = (op_q == OP_EQ);
    last_bit = (cnt == LAST_BIT);
    maj_bit  = (sh_a[0] & sh_b[0]) | (sh_a[0] & cy) | (sh_b[0] & cy);
    if (is_eq) begin
      sum_bit = sh_a[0] ^ sh_b[0];
    end else begin
      sum_bit = sh_a[0] ^ sh_b[0] ^ cy;
    end
    // New sum bit enters at the MSB so the first bit ends up at bit 0.
    res_full = {sum_bit, acc};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH bits, one DONE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nx = DONE;
        end else begin
          state_nx = RUN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state flops.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand shift registers, carry flop, counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      op_q  <= 2'b00;
      cy    <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      carry <= 1'b0;
      eq    <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            // SUB is a + ~b + 1: invert b here, the +1 comes from the carry preset.
            sh_b <= (op == OP_SUB) ? ~b : b;
            op_q <= op;
            cy   <= (op == OP_SUB);
            cnt  <= '0;
            acc  <= '0;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          acc  <= res_full[WIDTH-1:1];
          cnt  <= cnt + CNT_W'(1);
          if (!is_eq) begin
            cy <= maj_bit;
          end
          if (last_bit) begin
            s     <= res_full;
            carry <= is_eq ? 1'b0 : maj_bit;
            // Equality for EQ (a^b == 0), zero flag for ADD/SUB.
            eq    <= (res_full == '0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            ovf   <= (!is_eq) & (cy ^ maj_bit);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: scoreboard of expected results
// pushed when an operation is issued and popped on every done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         carry;
  logic         eq;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .carry (carry),
    .eq    (eq)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         e;
    logic         v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    if (obs === expv) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference model of one operation, using plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       r;
    logic [W:0] t;
    r.v = 1'b0;
    case (o)
      2'b01: begin
        t   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r.s = t[W-1:0];
        r.c = t[W];
        r.e = (r.s == '0);
        r.v = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
      end
      2'b10: begin
        r.s = x ^ y;
        r.c = 1'b0;
        r.e = (x == y);
      end
      default: begin
        t   = {1'b0, x} + {1'b0, y};
        r.s = t[W-1:0];
        r.c = t[W];
        r.e = (r.s == '0);
        r.v = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("s", {27'd0, s}, {27'd0, mon_e.s});
        check("carry", {31'd0, carry}, {31'd0, mon_e.c});
        check("eq", {31'd0, eq}, {31'd0, mon_e.e});
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.v});
`endif
      end
    end
    prev_done <= done;
  end

  // Wait (bounded) for done, then one more cycle to return to IDLE.
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  // Issue one op from IDLE (called at a negedge); scrambles inputs after accept.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 2'($urandom);
    wait_done(20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_done;
    int last_cyc;
    int guard;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {27'd0, s}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_eq", {31'd0, eq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD timing: busy for RUN + DONE, done only after edge WIDTH.
    op    = 2'b00;
    a     = 5'b00001;
    b     = 5'b00001;
    start = 1'b1;
    sb_q.push_back(model(2'b00, 5'b00001, 5'b00001));
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("run_busy", {31'd0, busy}, 32'd1);
      check("run_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_high", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("hold_s", {27'd0, s}, 32'd2);

    // Directed ADD / SUB / EQ cases.
    run_op(2'b00, 5'b10101, 5'b10100);
    run_op(2'b00, 5'b11100, 5'b00011);
    run_op(2'b00, 5'b01100, 5'b00100);
    run_op(2'b01, 5'b00001, 5'b00100);
    run_op(2'b01, 5'b00100, 5'b00100);
    run_op(2'b10, 5'b01100, 5'b01100);
    run_op(2'b10, 5'b00001, 5'b00000);
    run_op(2'b11, 5'b01111, 5'b10001);
    run_op(2'b01, 5'b00000, 5'b11111);
    run_op(2'b00, 5'b11111, 5'b00001);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end

    // Reset on the 3rd RUN edge aborts the op and clears all outputs.
    op    = 2'b00;
    a     = 5'b00111;
    b     = 5'b00010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_s", {27'd0, s}, 32'd0);
    check("abort_carry", {31'd0, carry}, 32'd0);
    check("abort_eq", {31'd0, eq}, 32'd0);
    run_op(2'b00, 5'b00001, 5'b00001);
    check("after_abort_s", {27'd0, s}, 32'd2);

    // start pulsed during RUN is ignored.
    op    = 2'b00;
    a     = 5'b00011;
    b     = 5'b00101;
    start = 1'b1;
    sb_q.push_back(model(2'b00, 5'b00011, 5'b00101));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op    = 2'b01;
    a     = 5'b11000;
    b     = 5'b00111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("ignored_start_busy", {31'd0, busy}, 32'd0);

    // start held high: back-to-back ops every WIDTH+2 cycles.
    op       = 2'b00;
    a        = W'($urandom);
    b        = W'($urandom);
    start    = 1'b1;
    sb_q.push_back(model(op, a, b));
    cnt_done = 0;
    last_cyc = -1;
    guard    = 0;
    while (cnt_done < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (done) begin
        cnt_done++;
        if (last_cyc >= 0) begin
          check("b2b_period", cyc - last_cyc, 32'd7);
        end
        last_cyc = cyc;
        if (cnt_done < 3) begin
          a = W'($urandom);
          b = W'($urandom);
          sb_q.push_back(model(op, a, b));
        end else begin
          start = 1'b0;
        end
      end
    end
    check("b2b_count", cnt_done, 32'd3);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
